// File: rtl/drac_pkg.sv
// Shared types and encodings for the data-memory responder.
package drac_pkg;

    localparam int ADDR_W = 40;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [63:0]       bus64_t;

    localparam logic [4:0] CMD_LOAD  = 5'b00000;
    localparam logic [4:0] CMD_STORE = 5'b00001;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Offset bits that must be zero for an access of the given size.
    function automatic logic [2:0] size_lsb_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a core data port and dmem_responder.
interface dmem_responder_if;
    import drac_pkg::*;

    logic        dmem_req_valid_i;
    logic        dmem_req_ready_o;
    logic [4:0]  dmem_req_cmd_i;
    addr_t       dmem_req_addr_i;
    logic [3:0]  dmem_op_type_i;
    bus64_t      dmem_req_data_i;
    logic [7:0]  dmem_req_tag_i;
    logic        dmem_req_kill_i;

    logic        dmem_resp_valid_o;
    bus64_t      dmem_resp_data_o;
    logic [7:0]  dmem_resp_tag_o;
    logic        dmem_resp_nack_o;
    logic        dmem_resp_replay_o;
    logic        dmem_xcpt_ma_ld_o;
    logic        dmem_xcpt_ma_st_o;
    logic        dmem_xcpt_pf_ld_o;
    logic        dmem_xcpt_pf_st_o;

    modport master (
        output dmem_req_valid_i, dmem_req_cmd_i, dmem_req_addr_i, dmem_op_type_i,
               dmem_req_data_i, dmem_req_tag_i, dmem_req_kill_i,
        input  dmem_req_ready_o, dmem_resp_valid_o, dmem_resp_data_o, dmem_resp_tag_o,
               dmem_resp_nack_o, dmem_resp_replay_o, dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o,
               dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o
    );

    modport slave (
        input  dmem_req_valid_i, dmem_req_cmd_i, dmem_req_addr_i, dmem_op_type_i,
               dmem_req_data_i, dmem_req_tag_i, dmem_req_kill_i,
        output dmem_req_ready_o, dmem_resp_valid_o, dmem_resp_data_o, dmem_resp_tag_o,
               dmem_resp_nack_o, dmem_resp_replay_o, dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o,
               dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o
    );

endinterface

// File: rtl/dmem_resp_align.sv
// Byte-lane select, store merge and load extract/extend for one 64-bit word.
// DMEM_RESP_XCPT_MA_EN: report misalignment instead of silently aligning down.
module dmem_resp_align
    import drac_pkg::*;
(
    input  logic [2:0] offset,
    input  logic [1:0] size,
    input  logic       is_unsigned,
    input  bus64_t     st_data,
    input  bus64_t     rd_word,
    output logic       misaligned,
    output logic [7:0] byte_en,
    output bus64_t     wr_word,
    output bus64_t     ld_data
);

    logic [2:0] lsb;
    logic [2:0] off;
    logic [7:0] base_en;
    bus64_t     shifted;
    logic       sx;

`ifdef DMEM_RESP_XCPT_MA_EN
    assign misaligned = |(offset & size_lsb_mask(size));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        lsb     = size_lsb_mask(size);
        off     = offset & ~lsb;
        case (size)
            SZ_B:    base_en = 8'h01;
            SZ_H:    base_en = 8'h03;
            SZ_W:    base_en = 8'h0F;
            default: base_en = 8'hFF;
        endcase
        byte_en = base_en << off;
        wr_word = st_data << {off, 3'b000};
        shifted = rd_word >> {off, 3'b000};
        sx      = ~is_unsigned;
        case (size)
            SZ_B:    ld_data = {{56{sx & shifted[7]}},  shifted[7:0]};
            SZ_H:    ld_data = {{48{sx & shifted[15]}}, shifted[15:0]};
            SZ_W:    ld_data = {{32{sx & shifted[31]}}, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder backed by a 64-bit word array.
// DMEM_RESP_XCPT_MA_EN (in dmem_resp_align) enables misaligned-access exceptions.
module dmem_responder
    import drac_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int MEM_DEPTH = 1024
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    dmem_responder_if.slave  bus
);

    localparam int    IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam addr_t DEPTH_A = addr_t'(MEM_DEPTH);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  cmd_q;
    addr_t       addr_q;
    logic [2:0]  op_q;
    bus64_t      data_q;
    logic [7:0]  tag_q;

    bus64_t      mem [MEM_DEPTH];
    logic [IDX_W-1:0] idx;
    logic        accept, in_range, is_ld, is_st, ok, resp_cyc, we;
    logic        misaligned;
    logic [7:0]  byte_en;
    bus64_t      wr_word, ld_data, rd_word;

    assign accept = (state_q == ST_IDLE) && bus.dmem_req_valid_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cmd_q  <= bus.dmem_req_cmd_i;
                addr_q <= bus.dmem_req_addr_i;
                op_q   <= bus.dmem_op_type_i[2:0];
                data_q <= bus.dmem_req_data_i;
                tag_q  <= bus.dmem_req_tag_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (bus.dmem_req_valid_i) begin
                if (LATENCY == 1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(LATENCY - 2);
                end
            end
            ST_WAIT: begin
                if (bus.dmem_req_kill_i)  state_d = ST_IDLE;
                else if (cnt_q == 4'd0)   state_d = ST_RESP;
                else                      cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign idx      = addr_q[IDX_W+2:3];
    assign in_range = {3'b000, addr_q[ADDR_W-1:3]} < DEPTH_A;
    assign is_ld    = (cmd_q == CMD_LOAD);
    assign is_st    = (cmd_q == CMD_STORE);
    assign ok       = (is_ld || is_st) && in_range;
    assign rd_word  = mem[idx];

    dmem_resp_align u_align (
        .offset      (addr_q[2:0]),
        .size        (op_q[1:0]),
        .is_unsigned (op_q[2]),
        .st_data     (data_q),
        .rd_word     (rd_word),
        .misaligned  (misaligned),
        .byte_en     (byte_en),
        .wr_word     (wr_word),
        .ld_data     (ld_data)
    );

    // A kill in the response cycle swallows every indicator and the write.
    assign resp_cyc = (state_q == ST_RESP) && !bus.dmem_req_kill_i;
    assign we       = resp_cyc && ok && !misaligned && is_st;

    always_comb begin
        bus.dmem_req_ready_o  = (state_q == ST_IDLE);
        bus.dmem_resp_valid_o = 1'b0;
        bus.dmem_resp_data_o  = '0;
        bus.dmem_resp_tag_o   = '0;
        bus.dmem_resp_nack_o  = 1'b0;
        bus.dmem_xcpt_ma_ld_o = 1'b0;
        bus.dmem_xcpt_ma_st_o = 1'b0;
        if (resp_cyc) begin
            bus.dmem_resp_tag_o = tag_q;
            if (!ok) begin
                bus.dmem_resp_nack_o = 1'b1;
            end else if (misaligned) begin
                bus.dmem_xcpt_ma_ld_o = is_ld;
                bus.dmem_xcpt_ma_st_o = is_st;
            end else begin
                bus.dmem_resp_valid_o = 1'b1;
                bus.dmem_resp_data_o  = is_ld ? ld_data : '0;
            end
        end
    end

    assign bus.dmem_resp_replay_o = 1'b0;
    assign bus.dmem_xcpt_pf_ld_o  = 1'b0;
    assign bus.dmem_xcpt_pf_st_o  = 1'b0;

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (latency 2 and 5) checked
// against a byte-level memory model with per-transaction timing expectations.
module tb_dmem_responder;
    import drac_pkg::*;

    localparam int LAT_A = 2, DEPTH_A = 1024;
    localparam int LAT_B = 5, DEPTH_B = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       req_valid = 1'b0, kill = 1'b0;
    logic [4:0] cmd = '0;
    addr_t      addr = '0;
    logic [3:0] op = '0;
    bus64_t     wdata = '0;
    logic [7:0] tag = '0;

    dmem_responder_if ifa();
    dmem_responder_if ifb();

    assign ifa.dmem_req_valid_i = req_valid & ~sel;
    assign ifb.dmem_req_valid_i = req_valid & sel;
    assign ifa.dmem_req_kill_i  = kill & ~sel;
    assign ifb.dmem_req_kill_i  = kill & sel;
    assign ifa.dmem_req_cmd_i   = cmd;   assign ifb.dmem_req_cmd_i   = cmd;
    assign ifa.dmem_req_addr_i  = addr;  assign ifb.dmem_req_addr_i  = addr;
    assign ifa.dmem_op_type_i   = op;    assign ifb.dmem_op_type_i   = op;
    assign ifa.dmem_req_data_i  = wdata; assign ifb.dmem_req_data_i  = wdata;
    assign ifa.dmem_req_tag_i   = tag;   assign ifb.dmem_req_tag_i   = tag;

    dmem_responder #(.LATENCY(LAT_A), .MEM_DEPTH(DEPTH_A)) u_a (.clk_i(clk), .rstn_i(rstn), .bus(ifa.slave));
    dmem_responder #(.LATENCY(LAT_B), .MEM_DEPTH(DEPTH_B)) u_b (.clk_i(clk), .rstn_i(rstn), .bus(ifb.slave));

    logic       o_ready, o_valid, o_nack, o_ma_ld, o_ma_st;
    logic [2:0] o_zero;
    logic [7:0] o_tag;
    bus64_t     o_data;
    assign o_ready = sel ? ifb.dmem_req_ready_o  : ifa.dmem_req_ready_o;
    assign o_valid = sel ? ifb.dmem_resp_valid_o : ifa.dmem_resp_valid_o;
    assign o_nack  = sel ? ifb.dmem_resp_nack_o  : ifa.dmem_resp_nack_o;
    assign o_ma_ld = sel ? ifb.dmem_xcpt_ma_ld_o : ifa.dmem_xcpt_ma_ld_o;
    assign o_ma_st = sel ? ifb.dmem_xcpt_ma_st_o : ifa.dmem_xcpt_ma_st_o;
    assign o_tag   = sel ? ifb.dmem_resp_tag_o   : ifa.dmem_resp_tag_o;
    assign o_data  = sel ? ifb.dmem_resp_data_o  : ifa.dmem_resp_data_o;
    assign o_zero  = sel ? {ifb.dmem_resp_replay_o, ifb.dmem_xcpt_pf_ld_o, ifb.dmem_xcpt_pf_st_o}
                         : {ifa.dmem_resp_replay_o, ifa.dmem_xcpt_pf_ld_o, ifa.dmem_xcpt_pf_st_o};

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", name, got, exp, $time, sel);
        end
    endtask

    task automatic quiet(input string name, input logic exp_ready);
        chk({name, "_flags"}, {o_valid, o_nack, o_ma_ld, o_ma_st, o_zero, o_tag}, '0);
        chk({name, "_data"}, o_data, '0);
        chk({name, "_ready"}, o_ready, exp_ready);
    endtask

    // Reference memory: words 0..15 of each instance, plus "fully written" flags.
    bus64_t mdl [2][16];
    bit     def [2][16];

    function automatic bus64_t ld_val(input bus64_t w, input int off, input int n, input bit uns);
        bus64_t r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = w[(off+i)*8 +: 8];
        if (!uns && n < 8 && r[n*8-1]) for (int i = n; i < 8; i++) r[i*8 +: 8] = 8'hFF;
        return r;
    endfunction

    // kill_at: 0 none, -1 kill together with the request, k>0 kill k cycles after acceptance.
    task automatic xact(input logic [4:0] c, input addr_t a, input logic [3:0] o,
                        input bus64_t d, input logic [7:0] t, input int kill_at);
        int  s     = sel ? 1 : 0;
        int  lat   = sel ? LAT_B : LAT_A;
        int  depth = sel ? DEPTH_B : DEPTH_A;
        int  n     = 1 << o[1:0];
        int  off   = int'(a[2:0]);
        int  aoff  = off - (off % n);
        int  w     = int'(a[9:3]);
        bit  ld    = (c == 5'd0);
        bit  st    = (c == 5'd1);
        bit  e_nack = !(ld || st) || ((a >> 3) >= addr_t'(depth));
        bit  e_ma, e_valid, known, killed;
        bus64_t e_ld;
`ifdef DMEM_RESP_XCPT_MA_EN
        e_ma = !e_nack && ((off % n) != 0);
`else
        e_ma = 1'b0;
`endif
        e_valid = !e_nack && !e_ma;
        known   = e_valid && ld && w < 16 && def[s][w];
        e_ld    = known ? ld_val(mdl[s][w], aoff, n, o[2]) : '0;
        killed  = 1'b0;

        chk("ready_idle", o_ready, 1'b1);
        cmd = c; addr = a; op = o; wdata = d; tag = t;
        req_valid = 1'b1;
        if (kill_at < 0) kill = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; kill = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k == kill_at) begin
                kill = 1'b1; #1;
                quiet("killed", 1'b0);
                @(posedge clk); #1;
                kill = 1'b0; killed = 1'b1;
                break;
            end
            if (k < lat) begin
                quiet("wait", 1'b0);
            end else begin
                chk("resp_valid", o_valid, e_valid);
                chk("resp_nack",  o_nack,  e_nack);
                chk("ma_ld",      o_ma_ld, e_ma && ld);
                chk("ma_st",      o_ma_st, e_ma && st);
                chk("resp_tag",   o_tag,   t);
                chk("const_zero", o_zero,  '0);
                chk("resp_ready", o_ready, 1'b0);
                if (e_valid && st) chk("st_data", o_data, '0);
                if (known)         chk("ld_data", o_data, e_ld);
            end
            @(posedge clk); #1;
        end
        quiet("after", 1'b1);
        if (st && e_valid && !killed && w < 16) begin
            for (int i = 0; i < n; i++) mdl[s][w][(aoff+i)*8 +: 8] = d[i*8 +: 8];
            if (n == 8) def[s][w] = 1'b1;
        end
    endtask

    task automatic rand_run(input int cnt);
        int lat   = sel ? LAT_B : LAT_A;
        int depth = sel ? DEPTH_B : DEPTH_A;
        for (int i = 0; i < cnt; i++) begin
            int r = $urandom_range(0, 19);
            int kr = $urandom_range(0, 19);
            logic [4:0] c;
            addr_t a;
            int ka;
            if (r < 9)       c = 5'd0;
            else if (r < 17) c = 5'd1;
            else             c = 5'($urandom_range(2, 31));
            if ($urandom_range(0, 9) == 0) a = addr_t'(depth * 8 + $urandom_range(0, 63));
            else                           a = addr_t'($urandom_range(0, 63));
            if (kr == 0)      ka = -1;
            else if (kr < 3)  ka = $urandom_range(1, lat);
            else              ka = 0;
            xact(c, a, 4'($urandom), {$urandom, $urandom}, 8'($urandom), ka);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) for (int w = 0; w < 16; w++) begin
            mdl[s][w] = '0; def[s][w] = 1'b0;
        end
        #2;
        quiet("in_reset", 1'b1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        quiet("post_reset_a", 1'b1);
        sel = 1'b1; #0;
        quiet("post_reset_b", 1'b1);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 8; w++) xact(5'd1, addr_t'(w*8), 4'd3, {$urandom, $urandom}, 8'(w), 0);
        end
        sel = 1'b0;

        // Directed scenarios on the latency-2 instance.
        xact(5'd1, 40'h10, 4'd3, 64'h1122334455667788, 8'h05, 0);
        xact(5'd0, 40'h10, 4'd3, '0, 8'h06, 0);
        chk("word_0x10", mdl[0][2], 64'h1122334455667788);
        xact(5'd0, 40'h17, 4'b0000, '0, 8'h07, 0);
        xact(5'd1, 40'h17, 4'b0000, 64'hF0, 8'h08, 0);
        xact(5'd0, 40'h17, 4'b0000, '0, 8'h09, 0);
        xact(5'd0, 40'h17, 4'b0100, '0, 8'h0A, 0);
        xact(5'd1, 40'h20, 4'd3, 64'hDEADBEEFCAFEF00D, 8'h0B, 1);
        xact(5'd0, 40'h20, 4'd3, '0, 8'h0C, 0);
        xact(5'd1, 40'h28, 4'd3, 64'h0123456789ABCDEF, 8'h0D, 2);
        xact(5'd0, 40'h28, 4'd3, '0, 8'h0E, 0);
        xact(5'd0, 40'h10, 4'd3, '0, 8'h0F, -1);
        xact(5'd0, addr_t'(DEPTH_A*8), 4'd3, '0, 8'h77, 0);
        xact(5'd2, 40'h10, 4'd3, '0, 8'h78, 0);
        xact(5'd0, 40'h12, 4'd2, '0, 8'h79, 0);
        xact(5'd1, 40'h13, 4'd1, 64'hABCD, 8'h7A, 0);
        xact(5'd0, 40'h10, 4'd3, '0, 8'h7B, 0);

        // Reset while a store waits: no response, no write.
        cmd = 5'd1; addr = 40'h30; op = 4'd3; wdata = 64'h5555AAAA5555AAAA; tag = 8'h99;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rstn = 1'b0; #1;
        quiet("rst_wait", 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            quiet("rst_release", 1'b1);
            @(posedge clk); #1;
        end
        xact(5'd0, 40'h30, 4'd3, '0, 8'h9A, 0);

        rand_run(80);
        sel = 1'b1;
        xact(5'd0, addr_t'(DEPTH_B*8), 4'd3, '0, 8'h42, 0);
        xact(5'd1, 40'h18, 4'd3, 64'hFEEDFACE00C0FFEE, 8'h43, 3);
        xact(5'd0, 40'h18, 4'd3, '0, 8'h44, 0);
        rand_run(50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response; legal range 1..15.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, meaning number of 64-bit words in the backing array.
REQ-003 SHALL provide: clk_i  in  1  clock. One clock; reset is asynchronous and active-low.
REQ-004 SHALL provide: rstn_i  in  1  asynchronous active-low reset.
REQ-005 SHALL provide: dmem_req_valid_i  in  1  request valid; dmem_req_ready_o  out  1  request accepted when valid&ready.
REQ-006 SHALL provide: dmem_req_cmd_i  in  5  command, 5'b00000 load, 5'b00001 store, others nack.
REQ-007 SHALL provide: dmem_req_addr_i  in  addr_t  byte address; dmem_op_type_i  in  4  [1:0] size B/H/W/D, [2] unsigned load.
REQ-008 SHALL provide: dmem_req_data_i  in  64  store data, LSB-aligned; dmem_req_tag_i  in  8  request tag.
REQ-009 SHALL provide: dmem_req_kill_i  in  1  cancels the outstanding request.
REQ-010 SHALL provide: dmem_resp_valid_o  out  1, dmem_resp_data_o  out  64, dmem_resp_tag_o  out  8, dmem_resp_nack_o  out  1, dmem_resp_replay_o  out  1.
REQ-011 SHALL provide: dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o, dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o  out  1 each.

Function
REQ-012 SHALL implement FSM IDLE, WAIT, RESP; dmem_req_ready_o=1 only in IDLE.
REQ-013 Acceptance in IDLE SHALL capture cmd, addr, op_type, data, tag and go to RESP if LATENCY=1, else to WAIT with counter=LATENCY-2.
REQ-014 WAIT SHALL decrement the counter each cycle and go to RESP when it reads 0; request-to-response latency is exactly LATENCY cycles.
REQ-015 RESP SHALL last exactly one cycle, assert exactly one response indicator, then return to IDLE; next acceptance is earliest the following cycle.
REQ-016 Load response SHALL set resp_valid=1, tag=captured tag, data=selected bytes of word addr[..:3], sign-extended unless op_type[2]=1.
REQ-017 Store SHALL write only the size-selected bytes at the addressed offset in the RESP cycle and assert resp_valid=1 with data=0.
REQ-018 Word index >= MEM_DEPTH or unsupported cmd SHALL give resp_nack=1, resp_valid=0, no array write.
REQ-019 dmem_req_kill_i=1 in WAIT or RESP SHALL return FSM to IDLE next cycle, suppress all response outputs that cycle, and block the store write; kill in IDLE SHALL be ignored.
REQ-020 dmem_resp_replay_o and both pf exception outputs SHALL be constant 0.
REQ-021 All response outputs SHALL be 0 outside RESP; resp_tag SHALL be valid in RESP for valid, nack or exception.

Reset
REQ-022 rstn_i low SHALL asynchronously force IDLE, counter 0, ready=1 after deassertion, all response/exception outputs 0; array contents undefined.
REQ-023 Reset during WAIT/RESP SHALL drop the outstanding request with no response and no write.

Configuration
REQ-024 With DMEM_RESP_XCPT_MA_EN defined, an address not aligned to its size SHALL, in RESP, assert xcpt_ma_ld (load) or xcpt_ma_st (store) instead of resp_valid, with no write.
REQ-025 Without DMEM_RESP_XCPT_MA_EN, ma outputs SHALL be constant 0 and the address SHALL be aligned down to the access size.

Structure
REQ-026 Command encodings, op_type size codes and the FSM state enum SHALL live in drac_pkg; addr_t and bus64_t SHALL be reused from it.
REQ-027 Byte-lane select/extract/extend logic SHALL be a sub-module dmem_resp_align; the array and FSM stay in dmem_responder.

Verification
REQ-028 LATENCY=2: store D, addr 0x10, data 0x1122334455667788, tag 0x05 -> ready low 2 cycles, resp_valid with tag 0x05 at T+2; then load D 0x10 -> data 0x1122334455667788.
REQ-029 Load B signed addr 0x17 of that word -> 0x0000000000000011 (0x11 positive); store B 0xF0 at 0x17, load B signed -> 0xFFFFFFFFFFFFFFF0, unsigned -> 0x00000000000000F0.
REQ-030 Store D addr 0x20, kill asserted cycle after acceptance -> no resp_valid, ready back next cycle, later load 0x20 returns prior contents.
REQ-031 Load addr MEM_DEPTH*8 -> resp_nack=1, resp_valid=0 at T+LATENCY, tag echoed.
REQ-032 With macro: load W addr 0x12 -> xcpt_ma_ld=1, resp_valid=0; without macro -> resp_valid=1 with word at 0x10.
REQ-033 Reset asserted in WAIT -> no response ever issued, ready=1 after release, all outputs 0.
